conv_unit_fx: RTL and testbench

Parametrised fixed-point 1-D convolution engine. It is built as a transposed systolic chain of KERNEL_N MAC cells with a shift-loaded kernel and bias. It adds what the earlier convolution unit lacks:
- a configuration state machine
- a valid/ready input handshake
- warm-up tracking, so only full-window outputs are flagged valid
- wide accumulation with a binary-point rescale and saturation

It sits between the feature-map fetch DMA and the pooling stage of the face-detection datapath.

---
 rtl/conv_pkg.sv | 50 +++++
 rtl/conv_mac_cell.sv | 38 +++
 rtl/conv_unit_fx.sv | 190 +++++++++++++++++++
 tb/tb_conv_unit_fx.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the fixed-point 1-D convolution engine.
//   conv_state_e : configuration / run state machine encoding
//   conv_acc_w   : accumulator width for a given sample width and tap count
//   rescale_sat  : binary-point rescale (floor) plus clip to a signed width
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        LOAD_B = 2'd2,
        RUN    = 2'd3
    } conv_state_e;

    // Working width of the output-stage arithmetic; wide enough for any
    // accumulator plus a shifted bias for the supported parameter range.
    localparam int SAT_W = 64;

    localparam logic signed [SAT_W-1:0] SAT_ONE = 1;

    // Full-width products summed over KERNEL_N taps cannot overflow this.
    function automatic int conv_acc_w(input int data_w, input int kernel_n);
        return 2 * data_w + $clog2(kernel_n);
    endfunction

    // Arithmetic shift right by frac_w (rounds toward minus infinity), then
    // clip into [-2^(data_w-1), 2^(data_w-1)-1]; clipped reports a clip.
    function automatic logic signed [SAT_W-1:0] rescale_sat(
        input  logic signed [SAT_W-1:0] s,
        input  int                      frac_w,
        input  int                      data_w,
        output logic                    clipped
    );
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        shifted = s >>> frac_w;
        max_v   = (SAT_ONE <<< (data_w - 1)) - SAT_ONE;
        min_v   = -max_v - SAT_ONE;
        clipped = 1'b0;
        if (shifted > max_v) begin
            clipped = 1'b1;
            shifted = max_v;
        end else if (shifted < min_v) begin
            clipped = 1'b1;
            shifted = min_v;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/conv_mac_cell.sv
// One cell of the transposed systolic convolution chain.
//   clk, rst : clock, asynchronous active-high reset
//   en       : a new sample is present on x this cycle
//   clr      : synchronous clear of the partial sum (wins over en)
//   x, w     : signed sample and this cell's weight
//   acc_in   : partial sum from the next cell down the chain
//   acc_out  : registered partial sum acc_in + x*w
module conv_mac_cell
    import conv_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = conv_acc_w(16, 25)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [ACC_W-1:0]  acc_in,
    output logic signed [ACC_W-1:0]  acc_out
);

    logic signed [2*DATA_W-1:0] prod;

    assign prod = x * w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out <= '0;
        end else if (clr) begin
            acc_out <= '0;
        end else if (en) begin
            acc_out <= acc_in + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/conv_unit_fx.sv
// Fixed-point 1-D convolution engine: KERNEL_N-tap transposed systolic chain
// with shift-loaded kernel and bias, valid/ready input, warm-up tracking and
// a rescale/saturate output stage. Two cycles from accept to out_valid.
//   clk, rst  : clock, asynchronous active-high reset
//   cfg_load  : start loading KERNEL_N weights then one bias word
//   flush     : in RUN, clear chain and warm-up; kernel and bias are kept
//   in_data   : sample, weight or bias word; in_valid qualifies it
//   in_ready  : high in every state except IDLE
//   out_data  : saturated result; out_valid strobes it; out_sat = clipped
//   busy      : state machine is not IDLE
// Optional build macro CONV_RELU_EN: negative results are forced to zero and
// out_sat then only reports positive clipping.
module conv_unit_fx
    import conv_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int KERNEL_N = 25,
    parameter int FRAC_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_load,
    input  logic                     flush,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic                     out_sat,
    output logic                     busy
);

    localparam int ACC_W = conv_acc_w(DATA_W, KERNEL_N);
    localparam int CNT_W = $clog2(KERNEL_N + 1);

    conv_state_e state, state_nxt;

    logic [CNT_W-1:0]          tap_cnt;
    logic [CNT_W-1:0]          warm_cnt;
    logic signed [DATA_W-1:0]  w [KERNEL_N];
    logic signed [DATA_W-1:0]  bias;

    logic accept, flush_run, clr, take_w, take_b, take_x;

    logic signed [DATA_W-1:0]  x_p0;
    logic                      vld_p0, full_p0;
    logic signed [ACC_W-1:0]   c_p1 [KERNEL_N];
    logic                      vld_p1;

    logic signed [SAT_W-1:0]   sum_p1;
    logic signed [DATA_W-1:0]  sat_val_p1, res_p1;
    logic                      sat_clip_p1, res_sat_p1;

    assign busy     = (state != IDLE);
    assign in_ready = busy;
    assign accept   = in_valid && in_ready;

    // cfg_load overrides everything, including flush and a coincident word.
    assign flush_run = flush && (state == RUN) && !cfg_load;
    assign clr       = cfg_load || flush_run;
    assign take_w    = accept && !cfg_load && (state == LOAD_W);
    assign take_b    = accept && !cfg_load && (state == LOAD_B);
    assign take_x    = accept && !cfg_load && !flush && (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cfg_load) begin
            state_nxt = LOAD_W;
        end else begin
            case (state)
                LOAD_W:  if (take_w && tap_cnt == CNT_W'(KERNEL_N - 1)) state_nxt = LOAD_B;
                LOAD_B:  if (take_b) state_nxt = RUN;
                default: state_nxt = state;
            endcase
        end
    end

    // Kernel words enter at w[0] and shift up, so the first word loaded ends
    // in the last cell, which sees the oldest sample of each window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt <= '0;
            bias    <= '0;
            for (int g = 0; g < KERNEL_N; g++) w[g] <= '0;
        end else begin
            if (cfg_load) begin
                tap_cnt <= '0;
            end else if (take_w) begin
                tap_cnt <= tap_cnt + CNT_W'(1);
            end
            if (take_w) begin
                w[0] <= in_data;
                for (int g = 1; g < KERNEL_N; g++) w[g] <= w[g-1];
            end
            if (take_b) bias <= in_data;
        end
    end

    // Warm-up: number of samples accepted since RUN entry or flush, held at
    // KERNEL_N once the window is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_cnt <= '0;
        end else if (clr) begin
            warm_cnt <= '0;
        end else if (take_x && warm_cnt != CNT_W'(KERNEL_N)) begin
            warm_cnt <= warm_cnt + CNT_W'(1);
        end
    end

    // ---- stage p0: accepted sample registered ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_p0    <= '0;
            vld_p0  <= 1'b0;
            full_p0 <= 1'b0;
        end else begin
            if (take_x) x_p0 <= in_data;
            vld_p0  <= take_x;
            full_p0 <= take_x && (warm_cnt >= CNT_W'(KERNEL_N - 1));
        end
    end

    // ---- stage p1: systolic chain, c_p1[0] holds the finished window ----
    for (genvar g = 0; g < KERNEL_N; g++) begin : g_cell
        logic signed [ACC_W-1:0] acc_in;
        if (g == KERNEL_N - 1) begin : g_tail
            assign acc_in = '0;
        end else begin : g_body
            assign acc_in = c_p1[g+1];
        end
        conv_mac_cell #(
            .DATA_W(DATA_W),
            .ACC_W (ACC_W)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .en     (vld_p0),
            .clr    (clr),
            .x      (x_p0),
            .w      (w[g]),
            .acc_in (acc_in),
            .acc_out(c_p1[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0 && full_p0 && !clr;
        end
    end

    always_comb begin
        sum_p1      = SAT_W'(c_p1[0]) + (SAT_W'(bias) <<< FRAC_W);
        sat_clip_p1 = 1'b0;
        sat_val_p1  = DATA_W'(rescale_sat(sum_p1, FRAC_W, DATA_W, sat_clip_p1));
        res_p1      = sat_val_p1;
        res_sat_p1  = sat_clip_p1;
`ifdef CONV_RELU_EN
        if (sat_val_p1 < 0) begin
            res_p1     = '0;
            res_sat_p1 = 1'b0;
        end
`endif
    end

    // ---- stage p2: output register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= vld_p1 && !clr;
            out_sat   <= vld_p1 && !clr && res_sat_p1;
            if (vld_p1 && !clr) out_data <= res_p1;
        end
    end

endmodule

// File: tb/tb_conv_unit_fx.sv
// Bench for conv_unit_fx: two instances (FRAC_W=0 and FRAC_W=8, KERNEL_N=3)
// share one stimulus stream and are checked every cycle against a
// behavioural window model, plus literal expectations for key cases.
module tb_conv_unit_fx;

    localparam int K = 3;
    localparam int M_IDLE = 0;
    localparam int M_LW   = 1;
    localparam int M_LB   = 2;
    localparam int M_RUN  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cfg_load = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic signed [15:0] in_data = '0;

    logic signed [15:0] od0, od8;
    logic ov0, ov8, os0, os8, ir0, ir8, b0, b8;

    always #5 clk = ~clk;

    conv_unit_fx #(.DATA_W(16), .KERNEL_N(K), .FRAC_W(0)) dut0 (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir0),
        .out_data(od0), .out_valid(ov0), .out_sat(os0), .busy(b0));

    conv_unit_fx #(.DATA_W(16), .KERNEL_N(K), .FRAC_W(8)) dut8 (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir8),
        .out_data(od8), .out_valid(ov8), .out_sat(os8), .busy(b8));

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_en   = 1'b0;
    int  edge_n   = 0;
    int  mode_next = M_IDLE;
    int  mode_cur  = M_IDLE;

    int  wk [K];
    int  bias_m = 0;
    int  tapn   = 0;
    int  hist [$];

    bit  ev  [int];
    int  ed0 [int];
    int  ed8 [int];
    bit  es0 [int];
    bit  es8 [int];

    int  obs0 [$];
    int  obs8 [$];
    bit  obss0 [$];
    bit  e_now;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d exp=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Window sum in load order: k_0 pairs with the oldest sample.
    task automatic model_y(input int frac, output int y, output bit s);
        longint acc;
        acc = 0;
        for (int i = 0; i < K; i++) acc += longint'(wk[i]) * longint'(hist[i]);
        acc += longint'(bias_m) * (longint'(1) << frac);
        acc = acc >>> frac;
        s = 1'b0;
        if (acc > 32767) begin acc = 32767; s = 1'b1; end
        else if (acc < -32768) begin acc = -32768; s = 1'b1; end
`ifdef CONV_RELU_EN
        if (acc < 0) begin acc = 0; s = 1'b0; end
`endif
        y = int'(acc);
    endtask

    task automatic drop_pending();
        if (ev.exists(edge_n + 1)) ev.delete(edge_n + 1);
        if (ev.exists(edge_n + 2)) ev.delete(edge_n + 2);
    endtask

    task automatic model_apply(input bit c, input bit f, input bit v, input int d);
        bit acc_ok;
        int y0, y8;
        bit s0, s8;
        acc_ok = v && (mode_next != M_IDLE);
        if (c) begin
            mode_next = M_LW;
            tapn = 0;
            hist.delete();
            drop_pending();
            return;
        end
        case (mode_next)
            M_LW: if (acc_ok) begin
                wk[tapn] = d;
                tapn++;
                if (tapn == K) mode_next = M_LB;
            end
            M_LB: if (acc_ok) begin
                bias_m = d;
                hist.delete();
                mode_next = M_RUN;
            end
            M_RUN: begin
                if (f) begin
                    hist.delete();
                    drop_pending();
                end else if (acc_ok) begin
                    hist.push_back(d);
                    if (hist.size() > K) void'(hist.pop_front());
                    if (hist.size() == K) begin
                        model_y(0, y0, s0);
                        model_y(8, y8, s8);
                        ev[edge_n + 3]  = 1'b1;
                        ed0[edge_n + 3] = y0;
                        ed8[edge_n + 3] = y8;
                        es0[edge_n + 3] = s0;
                        es8[edge_n + 3] = s8;
                    end
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        edge_n++;
        mode_cur = mode_next;
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            e_now = ev.exists(edge_n);
            check("out_valid_f0", ov0, e_now);
            check("out_valid_f8", ov8, e_now);
            if (e_now) begin
                check("out_data_f0", od0, ed0[edge_n]);
                check("out_sat_f0",  os0, es0[edge_n]);
                check("out_data_f8", od8, ed8[edge_n]);
                check("out_sat_f8",  os8, es8[edge_n]);
            end
            check("busy_f0",     b0,  mode_cur != M_IDLE);
            check("in_ready_f0", ir0, mode_cur != M_IDLE);
            check("busy_f8",     b8,  mode_cur != M_IDLE);
            if (ov0) begin obs0.push_back(od0); obss0.push_back(os0); end
            if (ov8) obs8.push_back(od8);
        end
    end

    task automatic step(input bit c, input bit f, input bit v, input int d);
        @(negedge clk);
        cfg_load = c;
        flush    = f;
        in_valid = v;
        in_data  = 16'(d);
        model_apply(c, f, v, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic send(input int d);
        step(1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic load_cfg(input int k0, input int k1, input int k2, input int b);
        step(1'b1, 1'b0, 1'b0, 0);
        send(k0); send(k1); send(k2); send(b);
    endtask

    task automatic clear_obs();
        obs0.delete(); obs8.delete(); obss0.delete();
    endtask

    task automatic chk_obs0(input string nm, input int idx, input int exp);
        check(nm, (idx < obs0.size()) ? obs0[idx] : 99999, exp);
    endtask

    task automatic chk_obs8(input string nm, input int idx, input int exp);
        check(nm, (idx < obs8.size()) ? obs8[idx] : 99999, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        cfg_load = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        ev.delete();
        hist.delete();
        mode_next = M_IDLE;
        mode_cur  = M_IDLE;
        tapn = 0;
        bias_m = 0;
        foreach (wk[i]) wk[i] = 0;
        #1;
        check("rst_out_valid_f0", ov0, 0);
        check("rst_out_data_f0",  od0, 0);
        check("rst_out_sat_f0",   os0, 0);
        check("rst_busy_f0",      b0,  0);
        check("rst_in_ready_f0",  ir0, 0);
        check("rst_out_valid_f8", ov8, 0);
        check("rst_out_data_f8",  od8, 0);
        check("rst_busy_f8",      b8,  0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    function automatic int rnd(input bit full);
        if (full) return int'($urandom_range(65535, 0)) - 32768;
        return int'($urandom_range(600, 0)) - 300;
    endfunction

    initial begin
        do_reset();

        // Basic window: kernel 1,2,3 bias 10, stream 1,1,1,2
        load_cfg(1, 2, 3, 10);
        clear_obs();
        send(1); send(1); send(1); send(2);
        idle(4);
        check("t1_count", obs0.size(), 2);
        chk_obs0("t1_y0", 0, 16);
        chk_obs0("t1_y1", 1, 19);

        // Gapped stream, identity-on-newest kernel, negative bias
        load_cfg(0, 0, 1, -5);
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            send(7);
            idle(3);
        end
        idle(2);
        check("t2_count", obs0.size(), 2);
        chk_obs0("t2_y0", 0, 2);
        chk_obs8("t2_floor_f8", 0, -5);

        // Saturation both directions
        load_cfg(32767, 32767, 32767, 0);
        clear_obs();
        send(32767); send(32767); send(32767);
        idle(3);
        step(1'b0, 1'b1, 1'b0, 0);
        send(-32768); send(-32768); send(-32768);
        idle(4);
        check("t3_count", obs0.size(), 2);
        chk_obs0("t3_pos", 0, 32767);
        check("t3_pos_sat", (obss0.size() > 0) ? obss0[0] : 0, 1);
`ifdef CONV_RELU_EN
        chk_obs0("t3_neg_relu", 1, 0);
`else
        chk_obs0("t3_neg", 1, -32768);
        check("t3_neg_sat", (obss0.size() > 1) ? obss0[1] : 0, 1);
`endif

        // Q8 arithmetic: 0.5 taps, bias 1.0, samples 2.0 -> 4.0
        load_cfg(16'h0080, 16'h0080, 16'h0080, 16'h0100);
        clear_obs();
        send(16'h0200); send(16'h0200); send(16'h0200);
        idle(4);
        chk_obs8("t4_q8", 0, 16'h0400);
        chk_obs0("t4_int_sat", 0, 32767);

        // Mid-stream flush: only post-flush samples count
        load_cfg(1, 2, 3, 0);
        clear_obs();
        send(5); send(6);
        step(1'b0, 1'b1, 1'b0, 0);
        send(1); send(1); send(2);
        idle(4);
        check("t5_count", obs0.size(), 1);
        chk_obs0("t5_y", 0, 9);

        // flush + cfg_load together: must be loading afterwards
        step(1'b1, 1'b1, 1'b0, 0);
        clear_obs();
        send(1); send(1); send(1); send(0);
        send(1); send(2); send(3);
        idle(4);
        check("t6_count", obs0.size(), 1);
        chk_obs0("t6_y", 0, 6);

        // cfg_load coincident with an accept: word 99 is dropped
        step(1'b1, 1'b0, 1'b1, 99);
        send(0); send(0); send(1); send(0);
        clear_obs();
        send(-4); send(-4); send(-4);
        idle(4);
`ifdef CONV_RELU_EN
        chk_obs0("t7_relu", 0, 0);
`else
        chk_obs0("t7_neg", 0, -4);
`endif

        // Randomised streams with gaps and flushes
        for (int r = 0; r < 4; r++) begin
            load_cfg(rnd(r[0]), rnd(r[0]), rnd(r[0]), rnd(r[0]));
            for (int i = 0; i < 80; i++) begin
                int pick;
                pick = int'($urandom_range(99, 0));
                if (pick < 3)       step(1'b0, 1'b1, 1'b0, 0);
                else if (pick < 70) send(rnd(r[1] | r[0]));
                else                idle(1);
            end
            idle(4);
        end

        // Asynchronous reset with outputs in flight, then reload
        load_cfg(1, 2, 3, 10);
        send(100); send(200); send(300); send(400); send(500);
        do_reset();
        step(1'b0, 1'b0, 1'b1, 55);
        idle(2);
        load_cfg(1, 1, 1, 0);
        clear_obs();
        send(2); send(3); send(4);
        idle(4);
        check("t9_count", obs0.size(), 1);
        chk_obs0("t9_y", 0, 9);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
